// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: interrupt sources, mask write, CPU acknowledge and presentation outputs of intr_ctrl
interface intr_ctrl_if #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
);
    logic [N_SRC-1:0] SRC;
    logic             MASK_WE;
    logic [N_SRC-1:0] MASK_IN;
    logic             ACK;
    logic             INTR_SET;
    logic [ID_W-1:0]  INTR_ID;
    logic [N_SRC-1:0] PENDING;
    logic             BUSY;
    modport master (output SRC, MASK_WE, MASK_IN, ACK, input INTR_SET, INTR_ID, PENDING, BUSY);
    modport slave (input SRC, MASK_WE, MASK_IN, ACK, output INTR_SET, INTR_ID, PENDING, BUSY);
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: synchronized edge-triggered interrupt collector with fixed-priority presentation to a CPU
module intr_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic       CLK,
    input  logic       RST_N,
    intr_ctrl_if.slave bus
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;
    state_t state, state_n;
    logic [N_SRC-1:0] sync1, sync2, edge_q, pend, mask, rise, clr, elig;
    logic [2:0] vld;
    logic [ID_W-1:0] id_q, id_n, sel;
    logic set_q, set_n;
    // vld holds off edge detection until edge_q has loaded a synchronized sample after reset
    assign rise = sync2 & ~edge_q & {N_SRC{vld[2]}};
    assign elig = pend & mask;
    assign clr = (state == WAIT_ACK && bus.ACK) ? N_SRC'(1) << id_q : '0;
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) sel = elig[i] ? ID_W'(i) : sel;
    end
    always_comb begin
        set_n = state == IDLE && |elig;
        id_n = set_n ? sel : id_q;
        state_n = set_n ? WAIT_ACK : (state == WAIT_ACK && bus.ACK) ? IDLE : state;
    end
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else state <= state_n;
    // a rising edge in the same cycle as the clear wins, so no event is lost
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            edge_q <= '0;
            vld <= '0;
            pend <= '0;
            mask <= '0;
            set_q <= 1'b0;
            id_q <= '0;
        end else begin
            sync1 <= bus.SRC;
            sync2 <= sync1;
            edge_q <= sync2;
            vld <= {vld[1:0], 1'b1};
            pend <= (pend & ~clr) | rise;
            if (bus.MASK_WE) mask <= bus.MASK_IN;
            set_q <= set_n;
            id_q <= id_n;
        end
    end
    assign bus.INTR_SET = set_q;
    assign bus.INTR_ID = id_q;
    assign bus.PENDING = pend;
    assign bus.BUSY = state == WAIT_ACK;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed vector table plus hand-written sequences for priority, collision, held level and reset
module tb_intr_ctrl;
    logic CLK, RST_N;
    int checks = 0, errors = 0;
    intr_ctrl_if #(.N_SRC(8), .ID_W(3)) bus ();
    intr_ctrl #(.N_SRC(8), .ID_W(3)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] src;
        logic       mwe;
        logic [7:0] min;
        logic       ack;
        logic       e_set;
        logic [2:0] e_id;
        logic [7:0] e_pend;
        logic       e_busy;
    } vec_t;
    vec_t vec [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] src, input logic mwe, input logic [7:0] min, input logic ack);
        bus.SRC = src;
        bus.MASK_WE = mwe;
        bus.MASK_IN = min;
        bus.ACK = ack;
    endtask

    task automatic outs(input string nm, input logic s, input logic [2:0] id, input logic [7:0] p, input logic b);
        chk({nm, " set"}, 32'(bus.INTR_SET), 32'(s));
        chk({nm, " id"}, 32'(bus.INTR_ID), 32'(id));
        chk({nm, " pend"}, 32'(bus.PENDING), 32'(p));
        chk({nm, " busy"}, 32'(bus.BUSY), 32'(b));
    endtask

    int pulses;

    initial begin
        vec[0]  = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vec[1]  = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vec[2]  = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vec[3]  = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0};
        vec[4]  = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1};
        vec[5]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h20, 1'b1};
        vec[6]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0};
        vec[7]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0};
        vec[8]  = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0};
        vec[9]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0};
        vec[10] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0};
        vec[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h08, 1'b0};
        vec[12] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h08, 1'b0};
        vec[13] = '{8'h00, 1'b1, 8'h08, 1'b0, 1'b0, 3'd5, 8'h08, 1'b0};
        vec[14] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1};
        vec[15] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};

        RST_N = 1'b0;
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        #2;
        outs("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        step();
        RST_N = 1'b1;
        repeat (4) step();
        outs("idle after reset", 1'b0, 3'd0, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(vec[i].src, vec[i].mwe, vec[i].min, vec[i].ack);
            step();
            outs($sformatf("vec%0d", i), vec[i].e_set, vec[i].e_id, vec[i].e_pend, vec[i].e_busy);
        end

        // priority: sources 6 and 2 together, lower index first
        drive(8'h00, 1'b1, 8'hFF, 1'b0);
        step();
        drive(8'h44, 1'b0, 8'h00, 1'b0);
        step();
        step();
        step();
        outs("prio pend", 1'b0, 3'd3, 8'h44, 1'b0);
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();
        outs("prio first", 1'b1, 3'd2, 8'h44, 1'b1);
        step();
        outs("prio hold", 1'b0, 3'd2, 8'h44, 1'b1);
        drive(8'h00, 1'b0, 8'h00, 1'b1);
        step();
        outs("prio ack", 1'b0, 3'd2, 8'h40, 1'b0);
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();
        outs("prio second", 1'b1, 3'd6, 8'h40, 1'b1);
        drive(8'h00, 1'b0, 8'h00, 1'b1);
        step();
        outs("prio ack2", 1'b0, 3'd6, 8'h00, 1'b0);

        // collision: a fresh SRC[1] edge sets pending on the same edge as its ACK
        drive(8'h02, 1'b0, 8'h00, 1'b0);
        repeat (4) step();
        outs("coll present", 1'b1, 3'd1, 8'h02, 1'b1);
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        repeat (3) step();
        drive(8'h02, 1'b0, 8'h00, 1'b0);
        step();
        step();
        drive(8'h02, 1'b0, 8'h00, 1'b1);
        step();
        outs("coll ack", 1'b0, 3'd1, 8'h02, 1'b0);
        drive(8'h02, 1'b0, 8'h00, 1'b0);
        step();
        outs("coll repeat", 1'b1, 3'd1, 8'h02, 1'b1);
        drive(8'h00, 1'b0, 8'h00, 1'b1);
        step();
        outs("coll clear", 1'b0, 3'd1, 8'h00, 1'b0);

        // held level: one event only
        drive(8'h01, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            pulses += int'(bus.INTR_SET);
        end
        chk("held pulses", 32'(pulses), 32'd1);
        outs("held busy", 1'b0, 3'd0, 8'h01, 1'b1);

        // asynchronous reset while busy, SRC[0] still high
        RST_N = 1'b0;
        #1;
        outs("async reset", 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        step();
        RST_N = 1'b1;
        drive(8'h01, 1'b1, 8'hFF, 1'b0);
        step();
        drive(8'h01, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(bus.INTR_SET);
        end
        chk("post reset pulses", 32'(pulses), 32'd0);
        outs("post reset", 1'b0, 3'd0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, giving the number of interrupt sources (legal 2..16).
REQ-002 The block SHALL have parameter ID_W, default 3, giving the width of the source ID; it equals clog2(N_SRC).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port SRC, input, N_SRC bits: raw asynchronous interrupt lines, active-high.
REQ-006 The block SHALL have port MASK_WE, input, 1 bit: the mask write strobe.
REQ-007 The block SHALL have port MASK_IN, input, N_SRC bits: mask write data; 1 means enabled.
REQ-008 The block SHALL have port ACK, input, 1 bit: the CPU acknowledge of the presented interrupt, one cycle.
REQ-009 The block SHALL have port INTR_SET, output, 1 bit: a one-cycle pulse that drives the SET input of the downstream interrupt flag.
REQ-010 The block SHALL have port INTR_ID, output, ID_W bits: the ID of the source being presented.
REQ-011 The block SHALL have port PENDING, output, N_SRC bits: the current pending register.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high while an interrupt is presented and not yet acknowledged.

Function
REQ-013 Each SRC bit SHALL pass through a 2-flop synchronizer followed by a third flop for edge detection.
REQ-014 A synchronized 0->1 transition on source i SHALL set PENDING[i] on the next edge: 3 cycles from the SRC change to PENDING.
REQ-015 A level held high SHALL produce exactly one pending event; re-arming requires a return to 0.
REQ-016 The mask register SHALL load MASK_IN on a cycle where MASK_WE=1.
REQ-017 Masking SHALL NOT clear or block PENDING; it only gates selection.
REQ-018 The eligible vector SHALL be PENDING & MASK.
REQ-019 The state machine SHALL have two states: IDLE and WAIT_ACK.
REQ-020 In IDLE with any eligible bit set, the block SHALL select the lowest-index eligible source (bit 0 highest priority), latch its index into INTR_ID, assert INTR_SET for exactly that one cycle, and move to WAIT_ACK.
REQ-021 In WAIT_ACK, INTR_ID SHALL hold constant, BUSY=1, and INTR_SET=0, whatever new events arrive.
REQ-022 ACK=1 in WAIT_ACK SHALL clear PENDING[INTR_ID] and return the machine to IDLE on the same edge.
REQ-023 ACK in IDLE SHALL be ignored.
REQ-024 A new edge on source INTR_ID arriving in the same cycle as ACK SHALL win: PENDING stays 1 (set overrides clear).
REQ-025 After ACK, a further eligible source SHALL raise INTR_SET at the earliest on the cycle after the machine returns to IDLE, giving at least one idle cycle between pulses.
REQ-026 If a mask write disables the source being presented while in WAIT_ACK, the block SHALL stay in WAIT_ACK until ACK.
REQ-027 BUSY SHALL equal (state == WAIT_ACK).

Reset
REQ-028 RST_N=0 SHALL immediately (asynchronously) set: synchronizer and edge flops to 0, PENDING=0, MASK=0 (all disabled), state=IDLE, INTR_SET=0, INTR_ID=0, BUSY=0.
REQ-029 Reset asserted mid-presentation SHALL discard the presented interrupt and all pending events.
REQ-030 The release of RST_N is assumed synchronous to CLK by the system; SRC lines already high at release SHALL NOT create events, because the edge flop loads the synchronized value before the first compare.

Verification
REQ-031 The bench SHALL cover a single source: with MASK=0xFF, raise SRC[5] -> PENDING[5]=1 after 3 cycles, INTR_SET one-cycle pulse on the next cycle with INTR_ID=5, BUSY=1; then ACK -> PENDING[5]=0, BUSY=0.
REQ-032 The bench SHALL cover priority: with MASK=0xFF, raise SRC[6] and SRC[2] together -> first pulse has INTR_ID=2; after ACK, a second pulse has INTR_ID=6 at least 1 idle cycle later.
REQ-033 The bench SHALL cover masking: with MASK=0x00, pulse SRC[3] -> PENDING=0x08 and no INTR_SET; then write MASK=0x08 -> INTR_SET with INTR_ID=3 within 2 cycles.
REQ-034 The bench SHALL cover set/clear collision: while presenting ID 1, a new SRC[1] edge reaches the pending-set point in the same cycle as ACK -> PENDING[1] stays 1 and INTR_SET with ID 1 follows.
REQ-035 The bench SHALL cover held level and reset: SRC[0] held high for 20 cycles -> exactly one INTR_SET; then assert RST_N=0 while BUSY=1 -> all outputs 0 at once, with no pulse after release while SRC[0] stays high.
